cube_drive_decoder: RTL

- Sits on the receiving end of the 3x3x3 LED cube drive interface: 3 vertical power lines plus 9 row lines.
- Samples the multiplexed drive lines on each scan step and rebuilds the 27-voxel image the cube displays.
- Delivers one voxel frame per scan window over a valid/ready handshake.
- Used as an on-board monitor (ledr/ledg display) and as a self-check against the cube pattern sequencer.

---
 rtl/cube_pkg.sv | 17 +
 rtl/cube_sync2.sv | 20 ++
 rtl/cube_drive_decoder.sv | 99 +++++++++
 3 files changed

// File: rtl/cube_pkg.sv
// cube_pkg: shared LED cube constants, voxel index mapping and 27-bit popcount
package cube_pkg;
  localparam int CUBE_N = 3;
  localparam int VOXELS = 27;
  localparam int BOT = 0;
  localparam int MID = 1;
  localparam int TOP = 2;
  function automatic logic [4:0] vox_idx(input int l, input int r, input int v);
    return 5'(l * CUBE_N * CUBE_N + r * CUBE_N + v);
  endfunction
  function automatic logic [4:0] popcount27(input logic [VOXELS-1:0] x);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < VOXELS; i++) c = c + 5'(x[i]);
    return c;
  endfunction
endpackage

// File: rtl/cube_sync2.sv
// cube_sync2: W-bit 2-FF synchroniser; in clock, reset_n (async low), d_i; out q_o
module cube_sync2 #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      q_o    <= '0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end
endmodule

// File: rtl/cube_drive_decoder.sv
// cube_drive_decoder: rebuilds the 27-voxel cube image from scan-sampled drive lines; in clock reset_n scan_clk sync vert_pwr row_bot/mid/top frame_ready clear_overrun; out frame_valid frame lit_count frame_changed overrun frame_count phase
module cube_drive_decoder
  import cube_pkg::*;
#(
  parameter int FRAME_SAMPLES   = 3,
  parameter bit VERT_ACTIVE_LOW = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        scan_clk,
  input  logic        sync,
  input  logic [2:0]  vert_pwr,
  input  logic [2:0]  row_bot,
  input  logic [2:0]  row_mid,
  input  logic [2:0]  row_top,
  input  logic        frame_ready,
  input  logic        clear_overrun,
  output logic        frame_valid,
  output logic [26:0] frame,
  output logic [4:0]  lit_count,
  output logic        frame_changed,
  output logic        overrun,
  output logic [15:0] frame_count,
  output logic [3:0]  phase
);
  logic        scan_s, scan_q, strobe_q;
  logic [11:0] drv_s;
  logic [2:0]  act;
  logic [26:0] dec, acc_eff, merged;
  logic [3:0]  ph_eff;
  logic        done, hs;
  logic [3:0]  phase_q, phase_d;
  logic [26:0] acc_q, acc_d, frame_q, frame_d;
  logic [4:0]  lit_q, lit_d;
  logic        changed_q, changed_d, valid_q, valid_d, overrun_q, overrun_d;
  logic [15:0] count_q, count_d;
  cube_sync2 #(.W(1)) u_sync_scan (
    .clock(clock), .reset_n(reset_n), .d_i(scan_clk), .q_o(scan_s)
  );
  cube_sync2 #(.W(12)) u_sync_drv (
    .clock(clock), .reset_n(reset_n),
    .d_i({row_top, row_mid, row_bot, vert_pwr}), .q_o(drv_s)
  );
  always_comb begin
    act = VERT_ACTIVE_LOW ? ~drv_s[2:0] : drv_s[2:0];
    dec = '0;
    for (int l = 0; l < CUBE_N; l++)
      for (int r = 0; r < CUBE_N; r++)
        for (int v = 0; v < CUBE_N; v++)
          dec[vox_idx(l, r, v)] = act[v] & drv_s[3 + l * CUBE_N + r];
  end
  always_comb begin
    ph_eff    = sync ? 4'd0 : phase_q;
    acc_eff   = sync ? '0 : acc_q;
    merged    = acc_eff | dec;
    done      = strobe_q && (ph_eff == 4'(FRAME_SAMPLES - 1));
    hs        = valid_q && frame_ready;
    phase_d   = done ? 4'd0 : strobe_q ? ph_eff + 4'd1 : ph_eff;
    acc_d     = done ? '0 : strobe_q ? merged : acc_eff;
    frame_d   = done ? merged : frame_q;
    lit_d     = done ? popcount27(merged) : lit_q;
    changed_d = done ? (merged != frame_q) : changed_q;
    valid_d   = done | (valid_q & ~hs);
    overrun_d = (done & valid_q & ~hs) | (overrun_q & ~clear_overrun);
    count_d   = count_q + 16'(done);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scan_q    <= 1'b0;
      strobe_q  <= 1'b0;
      phase_q   <= '0;
      acc_q     <= '0;
      frame_q   <= '0;
      lit_q     <= '0;
      changed_q <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      count_q   <= '0;
    end else begin
      scan_q    <= scan_s;
      strobe_q  <= scan_q & ~scan_s;
      phase_q   <= phase_d;
      acc_q     <= acc_d;
      frame_q   <= frame_d;
      lit_q     <= lit_d;
      changed_q <= changed_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      count_q   <= count_d;
    end
  end
  assign frame_valid   = valid_q;
  assign frame         = frame_q;
  assign lit_count     = lit_q;
  assign frame_changed = changed_q;
  assign overrun       = overrun_q;
  assign frame_count   = count_q;
  assign phase         = phase_q;
endmodule
